// File: rtl/load_store_unit.sv
// Load/store unit: decodes RV32 loads/stores, issues one data-memory bus access
// guarded by an ack timeout, and returns the extended load result with a done pulse.
//   state | meaning
//   IDLE  | waiting for a load/store; stalls the core combinationally on accept
//   BUSY  | bus request held stable until mem_ack or timeout
//   DONE  | one-cycle completion: done pulse, lsu_err on any failure
module load_store_unit #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [6:0]  opcode,
  input  logic [2:0]  fun3,
  input  logic [31:0] Alu_out,
  input  logic [31:0] readData2,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        done,
  output logic        lsu_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic        r_err;
  logic        r_is_load;
  logic [2:0]  r_fun3;
  logic [1:0]  r_lane;
  logic [31:0] r_load_data;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_be;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_accept;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_bad;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shift;
  logic [31:0] w_extract;

  assign w_is_load  = (opcode == OP_LOAD);
  assign w_is_store = (opcode == OP_STORE);
  assign w_accept   = (r_state == IDLE) && valid && (w_is_load || w_is_store);

  // Loads allow 000/001/010/100/101; stores allow only 000/001/010.
  assign w_illegal  = w_is_load ? ((fun3 == 3'b011) || (fun3[2:1] == 2'b11))
                                : (fun3 >= 3'b011);
  assign w_misalign = ((fun3[1:0] == 2'b01) && Alu_out[0]) ||
                      ((fun3[1:0] == 2'b10) && (Alu_out[1:0] != 2'b00));
  assign w_bad      = w_illegal || w_misalign;
  assign w_timeout  = (r_cnt == 8'(MAX_WAIT - 1));

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = readData2;
    case (fun3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << Alu_out[1:0];
        w_wdata = {4{readData2[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << Alu_out[1:0];
        w_wdata = {2{readData2[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_shift = mem_rdata >> {r_lane, 3'b000};

  always_comb begin
    w_extract = w_shift;
    case (r_fun3)
      3'b000:  w_extract = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b100:  w_extract = {24'd0, w_shift[7:0]};
      3'b001:  w_extract = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b101:  w_extract = {16'd0, w_shift[15:0]};
      default: w_extract = w_shift;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    stall   = 1'b0;
    done    = 1'b0;
    lsu_err = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          stall  = !rst;
          w_next = w_bad ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (mem_ack || w_timeout) w_next = DONE;
      end
      DONE: begin
        done    = 1'b1;
        lsu_err = r_err;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= 8'd0;
      r_err       <= 1'b0;
      r_is_load   <= 1'b0;
      r_fun3      <= 3'd0;
      r_lane      <= 2'd0;
      r_load_data <= 32'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_be    <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_fun3      <= fun3;
            r_lane      <= Alu_out[1:0];
            r_is_load   <= w_is_load;
            r_cnt       <= 8'd0;
            r_load_data <= 32'd0;
            r_err       <= w_bad;
            if (!w_bad) begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= w_is_store;
              r_mem_addr  <= {Alu_out[31:2], 2'b00};
              r_mem_be    <= w_be;
              r_mem_wdata <= w_wdata;
            end
          end
        end
        BUSY: begin
          // Ack in the final counted cycle takes priority over the timeout.
          if (mem_ack || w_timeout) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'd0;
            r_err       <= !mem_ack;
            r_load_data <= (mem_ack && r_is_load) ? w_extract : 32'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DONE: begin
          r_err       <= 1'b0;
          r_load_data <= 32'd0;
        end
        default: ;
      endcase
    end
  end

  assign load_data = r_load_data;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table of loads/stores with a completion
// scoreboard, plus hand sequences for non-memory opcodes and reset mid-BUSY.
module tb_load_store_unit;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [6:0]  opcode;
  logic [2:0]  fun3;
  logic [31:0] Alu_out;
  logic [31:0] readData2;
  logic        stall;
  logic [31:0] load_data;
  logic        done;
  logic        lsu_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  load_store_unit #(.MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .valid(valid), .opcode(opcode), .fun3(fun3),
    .Alu_out(Alu_out), .readData2(readData2), .stall(stall),
    .load_data(load_data), .done(done), .lsu_err(lsu_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          ack_cyc;   // 0 = never ack
    logic        exp_req;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_we;
    logic [31:0] exp_ld;
    logic        exp_err;
    int          exp_done;  // cycle of done relative to accept
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] ld;
    logic        err;
    int          done_cyc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got 0x%08h expected 0x%08h", nm, what, act, exp);
    end
  endtask

  function automatic vec_t mk(string nm, logic [6:0] op, logic [2:0] f3,
                              logic [31:0] addr, logic [31:0] wd, logic [31:0] rdata,
                              int ack, logic ereq, logic [31:0] emaddr, logic [3:0] ebe,
                              logic [31:0] ewdata, logic ewe, logic [31:0] eld,
                              logic eerr, int edone);
    vec_t v;
    v.name = nm; v.op = op; v.f3 = f3; v.addr = addr; v.wd = wd; v.rdata = rdata;
    v.ack_cyc = ack; v.exp_req = ereq; v.exp_maddr = emaddr; v.exp_be = ebe;
    v.exp_wdata = ewdata; v.exp_we = ewe; v.exp_ld = eld; v.exp_err = eerr;
    v.exp_done = edone;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    exp_t e;
    exp_t got;
    bit   seen;
    int   req_cycles;
    @(negedge clk);
    valid = 1'b1; opcode = v.op; fun3 = v.f3; Alu_out = v.addr;
    readData2 = v.wd; mem_rdata = v.rdata;
    #1 chk(v.name, "stall_c0", stall, 1'b1);
    e.name = v.name; e.ld = v.exp_ld; e.err = v.exp_err; e.done_cyc = v.exp_done;
    sb.push_back(e);
    seen = 1'b0;
    req_cycles = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      valid   = 1'b0;
      mem_ack = 1'b0;
      if (done) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          chk(v.name, "sb_nonempty", 32'd0, 32'd1);
        end else begin
          got = sb.pop_front();
          chk(got.name, "done_cycle", k, got.done_cyc);
          chk(got.name, "load_data", load_data, got.ld);
          chk(got.name, "lsu_err", lsu_err, got.err);
          chk(got.name, "stall_done", stall, 1'b0);
          chk(got.name, "mem_req_done", mem_req, 1'b0);
        end
      end else begin
        chk(v.name, "stall_busy", stall, 1'b1);
        chk(v.name, "lsu_err_busy", lsu_err, 1'b0);
        if (mem_req) begin
          req_cycles++;
          chk(v.name, "mem_addr", mem_addr, v.exp_maddr);
          chk(v.name, "mem_be", mem_be, v.exp_be);
          chk(v.name, "mem_wdata", mem_wdata, v.exp_wdata);
          chk(v.name, "mem_we", mem_we, v.exp_we);
        end
        if (k == v.ack_cyc) mem_ack = 1'b1;
      end
    end
    mem_ack = 1'b0;
    if (!seen) chk(v.name, "done_within_budget", 32'd0, 32'd1);
    chk(v.name, "req_cycles", req_cycles, v.exp_req ? v.exp_done - 1 : 0);
    @(negedge clk);
    chk(v.name, "done_one_cycle", done, 1'b0);
  endtask

  initial begin
    vecs.push_back(mk("LW_0x100",   LD, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1,
                      1, 32'h100, 4'b1111, 32'h0, 0, 32'hDEADBEEF, 0, 2));
    vecs.push_back(mk("LB_0x103",   LD, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 1,
                      1, 32'h100, 4'b1000, 32'h0, 0, 32'hFFFFFF80, 0, 2));
    vecs.push_back(mk("LBU_0x103",  LD, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 1,
                      1, 32'h100, 4'b1000, 32'h0, 0, 32'h00000080, 0, 2));
    vecs.push_back(mk("SH_0x202",   ST, 3'b001, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 1,
                      1, 32'h200, 4'b1100, 32'hABCDABCD, 1, 32'h0, 0, 2));
    vecs.push_back(mk("LW_mis",     LD, 3'b010, 32'h101, 32'h0, 32'h0, 1,
                      0, 32'h0, 4'b0, 32'h0, 0, 32'h0, 1, 1));
    vecs.push_back(mk("LH_f3_011",  LD, 3'b011, 32'h100, 32'h0, 32'h0, 1,
                      0, 32'h0, 4'b0, 32'h0, 0, 32'h0, 1, 1));
    vecs.push_back(mk("SB_0x301",   ST, 3'b000, 32'h301, 32'h000000A5, 32'h0, 3,
                      1, 32'h300, 4'b0010, 32'hA5A5A5A5, 1, 32'h0, 0, 4));
    vecs.push_back(mk("LH_0x102",   LD, 3'b001, 32'h102, 32'h0, 32'h80011234, 2,
                      1, 32'h100, 4'b1100, 32'h0, 0, 32'hFFFF8001, 0, 3));
    vecs.push_back(mk("LHU_0x102",  LD, 3'b101, 32'h102, 32'h0, 32'h80011234, 2,
                      1, 32'h100, 4'b1100, 32'h0, 0, 32'h00008001, 0, 3));
    vecs.push_back(mk("SW_0x400",   ST, 3'b010, 32'h400, 32'hCAFEF00D, 32'h12345678, 1,
                      1, 32'h400, 4'b1111, 32'hCAFEF00D, 1, 32'h0, 0, 2));
    vecs.push_back(mk("SH_mis",     ST, 3'b001, 32'h201, 32'h1234, 32'h0, 1,
                      0, 32'h0, 4'b0, 32'h0, 0, 32'h0, 1, 1));
    vecs.push_back(mk("SB_f3_011",  ST, 3'b011, 32'h300, 32'h55, 32'h0, 1,
                      0, 32'h0, 4'b0, 32'h0, 0, 32'h0, 1, 1));
    vecs.push_back(mk("SB_f3_100",  ST, 3'b100, 32'h300, 32'h55, 32'h0, 1,
                      0, 32'h0, 4'b0, 32'h0, 0, 32'h0, 1, 1));
    vecs.push_back(mk("LB_0x105",   LD, 3'b000, 32'h105, 32'h0, 32'h00007F00, 1,
                      1, 32'h104, 4'b0010, 32'h0, 0, 32'h0000007F, 0, 2));
    vecs.push_back(mk("LD_f3_110",  LD, 3'b110, 32'h100, 32'h0, 32'h0, 1,
                      0, 32'h0, 4'b0, 32'h0, 0, 32'h0, 1, 1));
    vecs.push_back(mk("LW_timeout", LD, 3'b010, 32'h500, 32'h0, 32'hAAAAAAAA, 0,
                      1, 32'h500, 4'b1111, 32'h0, 0, 32'h0, 1, 16));
    vecs.push_back(mk("LW_ack15",   LD, 3'b010, 32'h504, 32'h0, 32'h13579BDF, 15,
                      1, 32'h504, 4'b1111, 32'h0, 0, 32'h13579BDF, 0, 16));

    // Reset held with a load presented: every output must read zero.
    rst = 1'b1; valid = 1'b1; opcode = LD; fun3 = 3'b010; Alu_out = 32'h100;
    readData2 = 32'hFFFFFFFF; mem_rdata = 32'h0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset", "stall", stall, 1'b0);
    chk("reset", "done", done, 1'b0);
    chk("reset", "lsu_err", lsu_err, 1'b0);
    chk("reset", "mem_req", mem_req, 1'b0);
    chk("reset", "mem_we", mem_we, 1'b0);
    chk("reset", "mem_be", mem_be, 4'd0);
    chk("reset", "mem_addr", mem_addr, 32'd0);
    chk("reset", "mem_wdata", mem_wdata, 32'd0);
    chk("reset", "load_data", load_data, 32'd0);
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Non-memory opcode in IDLE: no stall, no bus activity, no completion.
    @(negedge clk);
    valid = 1'b1; opcode = 7'b0110011; fun3 = 3'b010; Alu_out = 32'h100;
    #1 chk("nonmem", "stall", stall, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("nonmem", "mem_req", mem_req, 1'b0);
      chk("nonmem", "done", done, 1'b0);
    end
    valid = 1'b0;

    // Reset in the middle of BUSY, then a late ack that must be ignored.
    @(negedge clk);
    valid = 1'b1; opcode = LD; fun3 = 3'b010; Alu_out = 32'h600; mem_rdata = 32'h11111111;
    @(negedge clk);
    valid = 1'b0;
    chk("rst_busy", "mem_req_before", mem_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", "mem_req", mem_req, 1'b0);
    chk("rst_busy", "mem_addr", mem_addr, 32'd0);
    chk("rst_busy", "mem_be", mem_be, 4'd0);
    chk("rst_busy", "stall", stall, 1'b0);
    chk("rst_busy", "done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("late_ack", "done", done, 1'b0);
      chk("late_ack", "lsu_err", lsu_err, 1'b0);
      chk("late_ack", "mem_req", mem_req, 1'b0);
      chk("late_ack", "stall", stall, 1'b0);
      @(negedge clk);
    end

    run_vec(mk("LW_after_rst", LD, 3'b010, 32'h700, 32'h0, 32'h0BADF00D, 1,
               1, 32'h700, 4'b1111, 32'h0, 0, 32'h0BADF00D, 0, 2));

    chk("scoreboard", "drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, the bus-ack timeout in BUSY cycles (legal 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port valid  input  1  an instruction is presented this cycle.
REQ-005 SHALL have port opcode  input  7  instruction opcode (0000011 load, 0100011 store).
REQ-006 SHALL have port fun3  input  3  access size and signedness.
REQ-007 SHALL have port Alu_out  input  32  effective byte address from the ALU.
REQ-008 SHALL have port readData2  input  32  store source register value.
REQ-009 SHALL have port stall  output  1  core holds PC and register-file write while high.
REQ-010 SHALL have port load_data  output  32  extended load result, valid when done=1.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port lsu_err  output  1  one-cycle pulse, coincident with done, on misalignment, illegal fun3 or timeout.
REQ-013 SHALL have ports mem_req/mem_we (out 1), mem_addr/mem_wdata (out 32), mem_be (out 4), mem_rdata (in 32), mem_ack (in 1): data-memory bus.

Function
REQ-014 SHALL implement states IDLE, BUSY, DONE.
REQ-015 In IDLE with valid=1 and a load/store opcode, stall SHALL be high combinationally in that same cycle.
REQ-016 Accepted, aligned, legal access: next state BUSY with registered mem_addr={Alu_out[31:2],2'b00}, mem_we=1 for store, mem_be, mem_wdata and mem_req=1.
REQ-017 Misaligned access (halfword with addr[0]=1, word with addr[1:0]!=0) or illegal fun3 (load 011/110/111, store >=011): next state DONE with lsu_err, no mem_req ever asserted.
REQ-018 Byte enables: SB 0001<<addr[1:0], SH 0011<<addr[1:0], SW 1111.
REQ-019 mem_wdata: SB byte replicated in all four lanes, SH halfword replicated in both halves, SW unchanged.
REQ-020 In BUSY, mem_req and all mem_* outputs SHALL stay stable until the cycle mem_ack=1 is sampled.
REQ-021 On mem_ack in BUSY: capture mem_rdata, next state DONE, mem_req low from DONE onward.
REQ-022 Load extract on lane addr[1:0]: LB sign-extend byte, LBU zero-extend byte, LH sign-extend half, LHU zero-extend half, LW full word.
REQ-023 load_data SHALL be 0 for stores and for any error completion.
REQ-024 Wait counter SHALL clear on BUSY entry and increment each BUSY cycle without ack; after MAX_WAIT ack-less cycles, next state DONE with lsu_err; ack in the final counted cycle wins (no error).
REQ-025 DONE lasts exactly one cycle: done=1, stall=0, inputs ignored, next state IDLE.
REQ-026 Minimum latency: accept in cycle 0, ack in cycle 1, done in cycle 2; stall high cycles 0-1.
REQ-027 mem_ack outside BUSY SHALL be ignored.
REQ-028 valid=0 or non-memory opcode in IDLE: stall=0, no state change, no bus activity.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, counter 0, and all outputs 0 (stall, done, lsu_err, mem_req, mem_we, mem_be, mem_addr, mem_wdata, load_data).
REQ-030 rst asserted mid-BUSY SHALL drop mem_req asynchronously; a late mem_ack after release SHALL be ignored.

Verification
REQ-031 LW addr 0x100, ack cycle 1, mem_rdata 0xDEADBEEF -> mem_be 1111, done cycle 2, load_data 0xDEADBEEF, stall high 2 cycles.
REQ-032 LB addr 0x103, mem_rdata 0x80FF_0000 -> load_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-033 SH addr 0x202, readData2 0x1234ABCD -> mem_addr 0x200, mem_be 1100, mem_wdata 0xABCDABCD, mem_we 1, load_data 0.
REQ-034 LW addr 0x101 -> no mem_req, done+lsu_err one cycle after accept; LH fun3 011 -> same.
REQ-035 MAX_WAIT=15, no ack -> mem_req held 15 cycles, then done+lsu_err, load_data 0; ack on 15th cycle -> done, no error.
REQ-036 rst pulse during BUSY -> all outputs 0 immediately, state IDLE, subsequent mem_ack ignored.
